// File: rtl/pkt_replicator_pkg.sv
// rtl/pkt_replicator_pkg.sv - shared encodings for the NoC packet replicator
package pkt_replicator_pkg;

    localparam logic [1:0] MODE_PASS     = 2'd0;
    localparam logic [1:0] MODE_REPL     = 2'd1;
    localparam logic [1:0] MODE_DROP     = 2'd2;
    localparam logic [1:0] MODE_PASS_ALT = 2'd3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FILL    = 2'd1;
    localparam logic [1:0] ST_PLAY    = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    localparam logic [7:0] SR_MODE_OFF    = 8'd0;
    localparam logic [7:0] SR_COPIES_OFF  = 8'd1;
    localparam logic [7:0] SR_RB_ADDR_OFF = 8'd2;

    localparam logic [1:0] RB_SEL_CFG  = 2'd0;
    localparam logic [1:0] RB_SEL_PKTS = 2'd1;
    localparam logic [1:0] RB_SEL_OVF  = 2'd2;
    localparam logic [1:0] RB_SEL_BAD  = 2'd3;

    localparam logic [63:0] RB_BADC0DE = 64'h0BADC0DE0BADC0DE;

    function automatic logic is_pass(input logic [1:0] mode);
        return (mode == MODE_PASS) || (mode == MODE_PASS_ALT);
    endfunction

endpackage

// File: rtl/pkt_replicator_ram.sv
// rtl/pkt_replicator_ram.sv - simple dual-port packet buffer with registered read
module pkt_replicator_ram #(
    parameter int WIDTH = 32,
    parameter int AWIDTH = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [2**AWIDTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/noc_pkt_replicator.sv
// rtl/noc_pkt_replicator.sv - pass / replicate-N / drop stage with settings bus
// Optional counters and their readback are built when PKT_REPLICATOR_STATS_EN is defined.
module noc_pkt_replicator
    import pkt_replicator_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int BUF_AWIDTH = 10,
    parameter int SR_BASE    = 131
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    output logic [63:0]      rb_data,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready
);

    localparam logic [7:0] ADDR_MODE   = 8'(SR_BASE) + SR_MODE_OFF;
    localparam logic [7:0] ADDR_COPIES = 8'(SR_BASE) + SR_COPIES_OFF;
    localparam logic [7:0] ADDR_RB     = 8'(SR_BASE) + SR_RB_ADDR_OFF;
    localparam logic [BUF_AWIDTH-1:0] WR_LAST = '1;

    logic [1:0]            mode_q, mode_d, active_mode_q, active_mode_d, rb_sel_q, rb_sel_d;
    logic [7:0]            copies_q, copies_d, active_copies_q, active_copies_d;
    logic [7:0]            copy_cnt_q, copy_cnt_d;
    logic [1:0]            state_q, state_d;
    logic                  in_pkt_q, in_pkt_d, s1_vld_q, s1_vld_d;
    logic                  out_vld_q, out_vld_d, out_last_q, out_last_d;
    logic [BUF_AWIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, last_idx_q, last_idx_d;
    logic [WIDTH-1:0]      out_data_q, out_data_d, byp_data_q, byp_data_d;
    logic [WIDTH-1:0]      ram_rd_data, src_data;
    logic                  acc, ram_wr_en;

    always_comb begin
        i_tready = 1'b0;
        o_tvalid = 1'b0;
        o_tdata  = '0;
        o_tlast  = 1'b0;
        if (!reset) begin
            if (is_pass(active_mode_q)) begin
                i_tready = o_tready;
                o_tvalid = i_tvalid;
                o_tdata  = i_tdata;
                o_tlast  = i_tlast;
            end else if (active_mode_q == MODE_DROP) begin
                i_tready = 1'b1;
            end else begin
                i_tready = (state_q != ST_PLAY);
                o_tvalid = out_vld_q;
                o_tdata  = out_data_q;
                o_tlast  = out_vld_q && out_last_q;
            end
        end
    end

    assign acc       = i_tvalid && i_tready;
    assign ram_wr_en = acc && (active_mode_q == MODE_REPL) &&
                       ((state_q == ST_IDLE) || (state_q == ST_FILL));
    // A 1-word packet is written in the same cycle its first read is issued, so it bypasses the RAM.
    assign src_data  = (last_idx_q == '0) ? byp_data_q : ram_rd_data;

    always_comb begin
        mode_d          = mode_q;
        copies_d        = copies_q;
        rb_sel_d        = rb_sel_q;
        if (set_stb) begin
            if (set_addr == ADDR_MODE)   mode_d   = set_data[1:0];
            if (set_addr == ADDR_COPIES) copies_d = (set_data[7:0] == 8'd0) ? 8'd1 : set_data[7:0];
            if (set_addr == ADDR_RB)     rb_sel_d = set_data[1:0];
        end
        state_d    = state_q;
        in_pkt_d   = acc ? !i_tlast : in_pkt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        last_idx_d = last_idx_q;
        copy_cnt_d = copy_cnt_q;
        s1_vld_d   = s1_vld_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        byp_data_d = (ram_wr_en && (wr_ptr_q == '0)) ? i_tdata : byp_data_q;
        case (state_q)
            ST_IDLE, ST_FILL: begin
                if (ram_wr_en) begin
                    if (i_tlast) begin
                        state_d    = ST_PLAY;
                        last_idx_d = wr_ptr_q;
                        wr_ptr_d   = '0;
                        rd_ptr_d   = '0;
                        copy_cnt_d = active_copies_q;
                        s1_vld_d   = 1'b1;
                    end else if (wr_ptr_q == WR_LAST) begin
                        state_d  = ST_DISCARD;
                        wr_ptr_d = '0;
                    end else begin
                        state_d  = ST_FILL;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            ST_DISCARD: begin
                if (acc && i_tlast) state_d = ST_IDLE;
            end
            default: begin
                if (out_vld_q && o_tready) out_vld_d = 1'b0;
                // RAM output always holds mem[rd_ptr_q]; holding rd_ptr on a stall holds the prefetched word.
                if (s1_vld_q && (!out_vld_q || o_tready)) begin
                    out_vld_d  = 1'b1;
                    out_data_d = src_data;
                    out_last_d = (rd_ptr_q == last_idx_q);
                    if (rd_ptr_q == last_idx_q) begin
                        if (copy_cnt_q <= 8'd1) begin
                            s1_vld_d = 1'b0;
                        end else begin
                            copy_cnt_d = copy_cnt_q - 1'b1;
                            rd_ptr_d   = '0;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end else if (!s1_vld_q && out_vld_q && o_tready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        active_mode_d   = active_mode_q;
        active_copies_d = active_copies_q;
        if ((state_d == ST_IDLE) && !in_pkt_d) begin
            active_mode_d   = mode_q;
            active_copies_d = copies_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q          <= MODE_PASS;
            copies_q        <= 8'd1;
            rb_sel_q        <= RB_SEL_CFG;
            active_mode_q   <= MODE_PASS;
            active_copies_q <= 8'd1;
            state_q         <= ST_IDLE;
            in_pkt_q        <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            last_idx_q      <= '0;
            copy_cnt_q      <= 8'd0;
            s1_vld_q        <= 1'b0;
            out_vld_q       <= 1'b0;
            out_data_q      <= '0;
            out_last_q      <= 1'b0;
            byp_data_q      <= '0;
        end else begin
            mode_q          <= mode_d;
            copies_q        <= copies_d;
            rb_sel_q        <= rb_sel_d;
            active_mode_q   <= active_mode_d;
            active_copies_q <= active_copies_d;
            state_q         <= state_d;
            in_pkt_q        <= in_pkt_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            last_idx_q      <= last_idx_d;
            copy_cnt_q      <= copy_cnt_d;
            s1_vld_q        <= s1_vld_d;
            out_vld_q       <= out_vld_d;
            out_data_q      <= out_data_d;
            out_last_q      <= out_last_d;
            byp_data_q      <= byp_data_d;
        end
    end

    pkt_replicator_ram #(
        .WIDTH  (WIDTH),
        .AWIDTH (BUF_AWIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (i_tdata),
        .rd_addr (rd_ptr_d),
        .rd_data (ram_rd_data)
    );

`ifdef PKT_REPLICATOR_STATS_EN
    logic [31:0] pkts_in_q, pkts_in_d, pkts_out_q, pkts_out_d, ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        pkts_in_d  = pkts_in_q + 32'(acc && i_tlast);
        pkts_out_d = pkts_out_q + 32'(o_tvalid && o_tready && o_tlast);
        ovf_cnt_d  = ovf_cnt_q + 32'((state_q == ST_DISCARD) && acc && i_tlast);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkts_in_q  <= '0;
            pkts_out_q <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            pkts_in_q  <= pkts_in_d;
            pkts_out_q <= pkts_out_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end
`endif

    always_comb begin
        rb_data = RB_BADC0DE;
        case (rb_sel_q)
            RB_SEL_CFG:  rb_data = {48'd0, 6'd0, mode_q, copies_q};
`ifdef PKT_REPLICATOR_STATS_EN
            RB_SEL_PKTS: rb_data = {pkts_in_q, pkts_out_q};
            RB_SEL_OVF:  rb_data = {32'd0, ovf_cnt_q};
`endif
            default:     rb_data = RB_BADC0DE;
        endcase
    end

endmodule

// File: tb/tb_noc_pkt_replicator.sv
// tb/tb_noc_pkt_replicator.sv - randomized self-checking bench for noc_pkt_replicator
module tb_noc_pkt_replicator;

    localparam int          SR_BASE = 131;
    localparam logic [63:0] BAD     = 64'h0BADC0DE0BADC0DE;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic [63:0] rb_data;
    logic [31:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b1;

    always #5 clk = ~clk;

    noc_pkt_replicator #(.WIDTH(32), .BUF_AWIDTH(4), .SR_BASE(SR_BASE)) dut (
        .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .rb_data(rb_data), .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
        .i_tready(i_tready), .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
        .o_tready(o_tready)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          tlast_cyc = 0;
    int          stab_err = 0;
    int          itr_err = 0;
    logic        rand_rdy = 1'b0;
    logic        repl_chk = 1'b0;
    logic        pass_chk = 1'b0;
    logic        prev_hold = 1'b0;
    logic [32:0] prev_beat = '0;
    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];
    int          got_cyc[$];
    logic [31:0] m_in = 0, m_out = 0, m_ovf = 0;
    logic [31:0] pk[$];

    always @(posedge clk) cyc++;

    always begin
        @(posedge clk);
        #1;
        o_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (prev_hold && !(o_tvalid && ({o_tlast, o_tdata} == prev_beat))) stab_err++;
            if (repl_chk && o_tvalid && i_tready) itr_err++;
            if (o_tvalid && o_tready) begin
                got_q.push_back({o_tlast, o_tdata});
                got_cyc.push_back(cyc);
            end
        end
        prev_hold = !reset && o_tvalid && !o_tready;
        prev_beat = {o_tlast, o_tdata};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] cfg_word(input logic [1:0] mode, input logic [7:0] copies);
        return {48'd0, 6'd0, mode, copies};
    endfunction

    // Reference: what a packet of n words should produce under a given mode and copy setting.
    task automatic model_pkt(input logic [31:0] w[$], input int mode, input int copies);
        int n = w.size();
        int c = (copies == 0) ? 1 : copies;
        m_in++;
        if (mode == 1) begin
            if (n > 16) begin
                m_ovf++;
            end else begin
                for (int k = 0; k < c; k++) begin
                    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), w[i]});
                    m_out++;
                end
            end
        end else if (mode != 2) begin
            for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), w[i]});
            m_out++;
        end
    endtask

    task automatic set_reg(input int addr, input logic [31:0] data);
        set_stb = 1'b1;
        set_addr = 8'(addr);
        set_data = data;
        @(posedge clk);
        #1;
        set_stb = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic read_rb(input string tag, input logic [1:0] sel, input logic [63:0] exp);
        set_reg(SR_BASE + 2, {30'd0, sel});
        @(negedge clk);
        check(tag, rb_data, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        int t = 0;
        i_tdata = d;
        i_tlast = l;
        i_tvalid = 1'b1;
        @(negedge clk);
        while (!i_tready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!i_tready) check("in_timeout", 64'(i_tready), 64'd1);
        if (pass_chk) check("pass_same_cycle", {30'd0, o_tvalid, o_tlast, o_tdata}, {30'd0, 1'b1, l, d});
        if (l) tlast_cyc = cyc;
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
        i_tlast = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] w[$]);
        for (int i = 0; i < w.size(); i++) send_beat(w[i], i == w.size() - 1);
    endtask

    task automatic rand_pkt(input int n);
        pk.delete();
        for (int i = 0; i < n; i++) pk.push_back($urandom);
    endtask

    task automatic drain_compare(input string tag);
        int t = 0;
        while (got_q.size() < exp_q.size() && t < 600) begin
            @(posedge clk);
            t++;
        end
        idle(6);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(tag, 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
        got_cyc.delete();
    endtask

    function automatic logic [63:0] exp_pkts();
`ifdef PKT_REPLICATOR_STATS_EN
        return {m_in, m_out};
`else
        return BAD;
`endif
    endfunction

    function automatic logic [63:0] exp_ovf();
`ifdef PKT_REPLICATOR_STATS_EN
        return {32'd0, m_ovf};
`else
        return BAD;
`endif
    endfunction

    initial begin
        int t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_i_tready", 64'(i_tready), 64'd0);
        check("rst_o_tvalid", 64'(o_tvalid), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out", {31'd0, o_tvalid, o_tlast, o_tdata}, 64'd0);
        check("rst_rb_cfg", rb_data, cfg_word(2'd0, 8'd1));
        @(posedge clk);
        #1;
        read_rb("rst_rb_pkts", 2'd1, exp_pkts());
        read_rb("rb_bad", 2'd3, BAD);

        // Pass-through, zero latency
        pass_chk = 1'b1;
        pk = '{32'h1, 32'h2, 32'h3, 32'h4};
        model_pkt(pk, 0, 1);
        send_pkt(pk);
        pass_chk = 1'b0;
        drain_compare("pass");
        read_rb("pass_pkts", 2'd1, exp_pkts());

        // Replicate x3, back-to-back output
        set_reg(SR_BASE, 1);
        set_reg(SR_BASE + 1, 3);
        idle(2);
        repl_chk = 1'b1;
        pk = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
        model_pkt(pk, 1, 3);
        send_pkt(pk);
        t = 0;
        while (got_q.size() < 15 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (got_cyc.size() >= 15) begin
            check("repl_first_latency", 64'(got_cyc[0] - tlast_cyc), 64'd2);
            check("repl_no_bubble", 64'(got_cyc[14] - got_cyc[0]), 64'd14);
        end else begin
            check("repl_beats_seen", 64'(got_cyc.size()), 64'd15);
        end
        drain_compare("repl3");
        read_rb("repl_pkts", 2'd1, exp_pkts());

        // Replicate x2 under random backpressure, including 1-word and full-buffer packets
        set_reg(SR_BASE + 1, 2);
        idle(2);
        rand_rdy = 1'b1;
        rand_pkt(1);
        model_pkt(pk, 1, 2);
        send_pkt(pk);
        rand_pkt(16);
        model_pkt(pk, 1, 2);
        send_pkt(pk);
        rand_pkt($urandom_range(2, 15));
        model_pkt(pk, 1, 2);
        send_pkt(pk);
        drain_compare("repl_stall");
        rand_rdy = 1'b0;
        check("stall_stable", 64'(stab_err), 64'd0);
        check("play_i_tready_low", 64'(itr_err), 64'd0);

        // Overflow: 20-word packet discarded, next packet still replicated
        rand_pkt(20);
        model_pkt(pk, 1, 2);
        send_pkt(pk);
        pk = '{32'h7, 32'h8, 32'h9};
        model_pkt(pk, 1, 2);
        send_pkt(pk);
        drain_compare("overflow");
        read_rb("ovf_cnt", 2'd2, exp_ovf());
        repl_chk = 1'b0;

        // DROP written mid-packet takes effect at the boundary
        set_reg(SR_BASE, 0);
        idle(2);
        pk = '{32'h11, 32'h12, 32'h13, 32'h14};
        model_pkt(pk, 0, 1);
        send_beat(32'h11, 1'b0);
        send_beat(32'h12, 1'b0);
        set_reg(SR_BASE, 2);
        idle(2);
        send_beat(32'h13, 1'b0);
        send_beat(32'h14, 1'b1);
        rand_pkt(3);
        model_pkt(pk, 2, 1);
        send_pkt(pk);
        drain_compare("drop");
        read_rb("drop_cfg", 2'd0, cfg_word(2'd2, 8'd2));
        read_rb("drop_pkts", 2'd1, exp_pkts());

        // copies=0 stores 1; reset while replicating
        set_reg(SR_BASE + 1, 0);
        read_rb("copies0_cfg", 2'd0, cfg_word(2'd2, 8'd1));
        set_reg(SR_BASE, 1);
        set_reg(SR_BASE + 1, 5);
        idle(2);
        rand_pkt(8);
        send_pkt(pk);
        t = 0;
        while (got_q.size() < 3 && t < 50) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("mid_play_valid", 64'(o_tvalid), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_o_tvalid", 64'(o_tvalid), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {62'd0, o_tvalid, i_tready}, 64'd1);
        check("post_rst_cfg", rb_data, cfg_word(2'd0, 8'd1));
        @(posedge clk);
        #1;
        m_in = 0;
        m_out = 0;
        m_ovf = 0;
        got_q.delete();
        got_cyc.delete();
        read_rb("post_rst_pkts", 2'd1, exp_pkts());
        read_rb("post_rst_ovf", 2'd2, exp_ovf());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
